// File: rtl/audio_mix_pkg.sv
// Shared definitions for the audio channel mixer.
//   mix_state_e      : sequencing states of the mixer
//   GAIN_W           : width of per-channel and master gain values
//   UNITY_GAIN       : gain code representing 1.0 (128/128)
//   ROUTE_L, ROUTE_R : bit positions inside each channel's 2-bit route field
package audio_mix_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_SCALE  = 2'd2,
    ST_OUTPUT = 2'd3
  } mix_state_e;

  localparam int              GAIN_W     = 8;
  localparam logic [GAIN_W-1:0] UNITY_GAIN = 8'd128;
  localparam int              ROUTE_L    = 0;
  localparam int              ROUTE_R    = 1;

endpackage

// File: rtl/audio_mix_sat.sv
// Saturate a wide signed value to the signed DW range, then align it to the
// OUT_W output width (zero-fill LSBs when widening, drop LSBs when narrowing).
//   din  : wide signed input value
//   dout : saturated, aligned signed output
//   clip : 1 when din lay outside the signed DW range
module audio_mix_sat #(
  parameter int IN_W  = 34,
  parameter int DW    = 16,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  din,
  output logic        [OUT_W-1:0] dout,
  output logic                    clip
);

  localparam int                    MAX_I   = (1 << (DW - 1)) - 1;
  localparam logic signed [IN_W-1:0] SAT_MAX = IN_W'(MAX_I);
  localparam logic signed [IN_W-1:0] SAT_MIN = IN_W'(-MAX_I - 1);

  logic signed [DW-1:0] sat;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    clip = 1'b0;
    sat  = din[DW-1:0];
    if (din > SAT_MAX) begin
      sat  = {1'b0, {(DW-1){1'b1}}};
      clip = 1'b1;
    end else if (din < SAT_MIN) begin
      sat  = {1'b1, {(DW-1){1'b0}}};
      clip = 1'b1;
    end
  end

  generate
    if (OUT_W > DW) begin : g_widen
      assign dout = {sat, {(OUT_W-DW){1'b0}}};
    end else if (OUT_W == DW) begin : g_same
      assign dout = sat;
    end else begin : g_narrow
      // Arithmetic shift then truncate keeps the top OUT_W bits.
      assign dout = OUT_W'(sat >>> (DW - OUT_W));
    end
  endgenerate

endmodule

// File: rtl/audio_channel_mixer.sv
// Multi-channel audio mixer: weights NUM_CH input samples by per-channel gains,
// routes them into left/right sums, applies a ramping master gain, saturates
// and presents one stereo sample through a valid/ready handshake.
//   clk_sys, reset_n          : clock and asynchronous active-low reset
//   sample_stb, ch_data       : one-cycle strobe with a packed sample set
//   ch_signed/ch_gain/ch_route: per-channel format, gain (128 = 1.0), routing
//   mute                      : ramp master gain down (1) or up (0) per transfer
//   out_valid/out_ready/out_l/out_r : stereo output handshake
//   busy, overrun, clip_l, clip_r, muted : status
module audio_channel_mixer
  import audio_mix_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int DW        = 16,
  parameter int OUT_W     = 16,
  parameter int RAMP_STEP = 1
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic                     sample_stb,
  input  logic [NUM_CH*DW-1:0]     ch_data,
  input  logic [NUM_CH-1:0]        ch_signed,
  input  logic [NUM_CH*GAIN_W-1:0] ch_gain,
  input  logic [NUM_CH*2-1:0]      ch_route,
  input  logic                     mute,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_l,
  output logic [OUT_W-1:0]         out_r,
  output logic                     busy,
  output logic                     overrun,
  output logic                     clip_l,
  output logic                     clip_r,
  output logic                     muted
);

  // Sum of NUM_CH products of DW x 9 bits cannot overflow this width.
  localparam int ACC_W  = DW + 9 + $clog2(NUM_CH);
  localparam int PROD_W = ACC_W + 9;
  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_CH - 1);
  localparam logic [GAIN_W:0]   STEP     = (GAIN_W + 1)'(RAMP_STEP);

  mix_state_e                state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [NUM_CH*DW-1:0]      data_q, data_d;
  logic [NUM_CH-1:0]         sgn_q, sgn_d;
  logic [NUM_CH*GAIN_W-1:0]  gain_q, gain_d;
  logic [NUM_CH*2-1:0]       route_q, route_d;
  logic signed [ACC_W-1:0]   acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [GAIN_W-1:0]         master_q, master_d;
  logic                      out_valid_q, out_valid_d;
  logic [OUT_W-1:0]          out_l_q, out_l_d, out_r_q, out_r_d;
  logic                      overrun_q, overrun_d;
  logic                      clip_l_q, clip_l_d, clip_r_q, clip_r_d;

  // Current channel term during ACCUM.
  logic [DW-1:0]             cur_raw, cur_smp;
  logic [1:0]                cur_route;
  logic signed [DW+8:0]      cur_prod;
  logic signed [ACC_W-1:0]   cur_term;

  // Master-gain scaling during SCALE.
  logic signed [GAIN_W:0]    master_s;
  logic signed [ACC_W-1:0]   sh_l, sh_r;
  logic signed [PROD_W-1:0]  scaled_l, scaled_r;
  logic [OUT_W-1:0]          sat_l, sat_r;
  logic                      sat_clip_l, sat_clip_r;
  logic [GAIN_W:0]           master_up;
  logic                      transfer;

  always_comb begin
    cur_raw   = data_q[int'(idx_q)*DW +: DW];
    // Offset binary becomes two's complement by flipping the MSB.
    cur_smp   = sgn_q[idx_q] ? cur_raw : {~cur_raw[DW-1], cur_raw[DW-2:0]};
    cur_prod  = $signed(cur_smp) * $signed({1'b0, gain_q[int'(idx_q)*GAIN_W +: GAIN_W]});
    cur_term  = ACC_W'(cur_prod);
    cur_route = route_q[int'(idx_q)*2 +: 2];

    master_s  = {1'b0, master_q};
    sh_l      = acc_l_q >>> 7;
    sh_r      = acc_r_q >>> 7;
    scaled_l  = (PROD_W'(sh_l) * PROD_W'(master_s)) >>> 7;
    scaled_r  = (PROD_W'(sh_r) * PROD_W'(master_s)) >>> 7;
    master_up = {1'b0, master_q} + STEP;
  end

  audio_mix_sat #(.IN_W(PROD_W), .DW(DW), .OUT_W(OUT_W)) u_sat_l (
    .din (scaled_l),
    .dout(sat_l),
    .clip(sat_clip_l)
  );

  audio_mix_sat #(.IN_W(PROD_W), .DW(DW), .OUT_W(OUT_W)) u_sat_r (
    .din (scaled_r),
    .dout(sat_r),
    .clip(sat_clip_r)
  );

  assign transfer = out_valid_q & out_ready;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    data_d      = data_q;
    sgn_d       = sgn_q;
    gain_d      = gain_q;
    route_d     = route_q;
    acc_l_d     = acc_l_q;
    acc_r_d     = acc_r_q;
    master_d    = master_q;
    out_valid_d = out_valid_q;
    out_l_d     = out_l_q;
    out_r_d     = out_r_q;
    overrun_d   = 1'b0;
    clip_l_d    = 1'b0;
    clip_r_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (sample_stb) begin
          data_d  = ch_data;
          sgn_d   = ch_signed;
          gain_d  = ch_gain;
          route_d = ch_route;
          acc_l_d = '0;
          acc_r_d = '0;
          idx_d   = '0;
          state_d = ST_ACCUM;
        end
      end

      ST_ACCUM: begin
        overrun_d = sample_stb;
        if (cur_route[ROUTE_L]) acc_l_d = acc_l_q + cur_term;
        if (cur_route[ROUTE_R]) acc_r_d = acc_r_q + cur_term;
        if (idx_q == LAST_IDX) state_d = ST_SCALE;
        else                   idx_d   = idx_q + IDX_W'(1);
      end

      ST_SCALE: begin
        overrun_d   = sample_stb;
        out_l_d     = sat_l;
        out_r_d     = sat_r;
        clip_l_d    = sat_clip_l;
        clip_r_d    = sat_clip_r;
        out_valid_d = 1'b1;
        state_d     = ST_OUTPUT;
      end

      ST_OUTPUT: begin
        if (transfer) begin
          out_valid_d = 1'b0;
          // The transferred sample was scaled with the old master gain.
          if (mute) begin
            master_d = ({1'b0, master_q} >= STEP) ? master_q - STEP[GAIN_W-1:0] : '0;
          end else begin
            master_d = (master_up >= {1'b0, UNITY_GAIN}) ? UNITY_GAIN : master_up[GAIN_W-1:0];
          end
          if (sample_stb) begin
            data_d  = ch_data;
            sgn_d   = ch_signed;
            gain_d  = ch_gain;
            route_d = ch_route;
            acc_l_d = '0;
            acc_r_d = '0;
            idx_d   = '0;
            state_d = ST_ACCUM;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          overrun_d = sample_stb;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  // NOTE: the latched sample registers are reset as well; they are few and a
  // known value keeps the datapath free of X after reset.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      data_q      <= '0;
      sgn_q       <= '0;
      gain_q      <= '0;
      route_q     <= '0;
      acc_l_q     <= '0;
      acc_r_q     <= '0;
      master_q    <= UNITY_GAIN;
      out_valid_q <= 1'b0;
      out_l_q     <= '0;
      out_r_q     <= '0;
      overrun_q   <= 1'b0;
      clip_l_q    <= 1'b0;
      clip_r_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      sgn_q       <= sgn_d;
      gain_q      <= gain_d;
      route_q     <= route_d;
      acc_l_q     <= acc_l_d;
      acc_r_q     <= acc_r_d;
      master_q    <= master_d;
      out_valid_q <= out_valid_d;
      out_l_q     <= out_l_d;
      out_r_q     <= out_r_d;
      overrun_q   <= overrun_d;
      clip_l_q    <= clip_l_d;
      clip_r_q    <= clip_r_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_l     = out_l_q;
  assign out_r     = out_r_q;
  assign overrun   = overrun_q;
  assign clip_l    = clip_l_q;
  assign clip_r    = clip_r_q;
  assign busy      = (state_q != ST_IDLE);
  assign muted     = (master_q == '0);

endmodule

// File: tb/tb_audio_channel_mixer.sv
// Self-checking bench for audio_channel_mixer (NUM_CH=4, DW=16, OUT_W=16,
// RAMP_STEP=16). Expected outputs come from an integer reference model.
module tb_audio_channel_mixer;

  localparam int NUM_CH    = 4;
  localparam int DW        = 16;
  localparam int OUT_W     = 16;
  localparam int RAMP_STEP = 16;

  logic                 clk_sys = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 sample_stb = 1'b0;
  logic [NUM_CH*DW-1:0] ch_data = '0;
  logic [NUM_CH-1:0]    ch_signed = '0;
  logic [NUM_CH*8-1:0]  ch_gain = '0;
  logic [NUM_CH*2-1:0]  ch_route = '0;
  logic                 mute = 1'b0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [OUT_W-1:0]     out_l, out_r;
  logic                 busy, overrun, clip_l, clip_r, muted;

  audio_channel_mixer #(
    .NUM_CH(NUM_CH), .DW(DW), .OUT_W(OUT_W), .RAMP_STEP(RAMP_STEP)
  ) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .sample_stb(sample_stb),
    .ch_data   (ch_data),
    .ch_signed (ch_signed),
    .ch_gain   (ch_gain),
    .ch_route  (ch_route),
    .mute      (mute),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_l     (out_l),
    .out_r     (out_r),
    .busy      (busy),
    .overrun   (overrun),
    .clip_l    (clip_l),
    .clip_r    (clip_r),
    .muted     (muted)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_pass   = 0;
  int mg       = 128;   // model of the master gain

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic longint fdiv128(input longint a);
    if (a >= 0) return a / 128;
    return -((-a + 127) / 128);
  endfunction

  function automatic void scale_ref(input longint s, input int g,
                                    output logic [15:0] o, output logic c);
    longint t;
    t = fdiv128(fdiv128(s) * g);
    c = (t > 32767) || (t < -32768);
    if (t > 32767)  t = 32767;
    if (t < -32768) t = -32768;
    o = t[15:0];
  endfunction

  function automatic void model(input logic [63:0] d, input logic [3:0] sg,
                                input logic [31:0] g, input logic [7:0] r, input int gm,
                                output logic [15:0] ol, output logic [15:0] orr,
                                output logic cl, output logic cr);
    longint sl = 0, sr = 0, raw, v, p;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      raw = longint'(d[ch*16 +: 16]);
      if (sg[ch]) v = (raw >= 32768) ? raw - 65536 : raw;
      else        v = raw - 32768;
      p = v * longint'(g[ch*8 +: 8]);
      if (r[ch*2])     sl += p;
      if (r[ch*2 + 1]) sr += p;
    end
    scale_ref(sl, gm, ol, cl);
    scale_ref(sr, gm, orr, cr);
  endfunction

  // ---------------- stimulus helpers ----------------
  // All helpers start and end just after a rising edge unless stated.
  task automatic start_sample(input logic [63:0] d, input logic [3:0] sg,
                              input logic [31:0] g, input logic [7:0] r);
    ch_data = d; ch_signed = sg; ch_gain = g; ch_route = r;
    sample_stb = 1'b1;
    @(posedge clk_sys); #1;
    sample_stb = 1'b0;
    // Scramble inputs so a design that fails to latch is exposed.
    ch_data   = {$urandom, $urandom};
    ch_signed = 4'($urandom);
    ch_gain   = $urandom;
    ch_route  = 8'($urandom);
  endtask

  // Polls on falling edges; returns at the falling edge where out_valid is seen.
  task automatic wait_valid(output int n);
    n = 0;
    forever begin
      @(negedge clk_sys);
      n++;
      if (out_valid) break;
      if (n > 64) begin
        check("valid_timeout", 32'd0, 32'd1);
        break;
      end
      @(posedge clk_sys); #1;
    end
  endtask

  // Starts at the falling edge of the first OUTPUT cycle.
  task automatic finish_transfer(input int hold);
    logic [15:0] keep_l;
    keep_l = out_l;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk_sys); #1;
      @(negedge clk_sys);
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_stable", {16'd0, out_l}, {16'd0, keep_l});
      check("clip_one_cycle", {30'd0, clip_l, clip_r}, 32'd0);
    end
    @(posedge clk_sys); #1;
    out_ready = 1'b1;
    @(posedge clk_sys); #1;
    out_ready = 1'b0;
    if (mute) mg = (mg >= RAMP_STEP) ? mg - RAMP_STEP : 0;
    else      mg = (mg + RAMP_STEP >= 128) ? 128 : mg + RAMP_STEP;
    @(negedge clk_sys);
    check("valid_drop", {31'd0, out_valid}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("muted_flag", {31'd0, muted}, {31'd0, (mg == 0)});
    @(posedge clk_sys); #1;
  endtask

  task automatic do_sample(input logic [63:0] d, input logic [3:0] sg,
                           input logic [31:0] g, input logic [7:0] r, input int hold,
                           output logic [15:0] ol, output logic [15:0] orr);
    logic [15:0] el, er;
    logic        ecl, ecr;
    int          n;
    model(d, sg, g, r, mg, el, er, ecl, ecr);
    start_sample(d, sg, g, r);
    wait_valid(n);
    check("latency", n, NUM_CH + 2);
    check("out_l", {16'd0, out_l}, {16'd0, el});
    check("out_r", {16'd0, out_r}, {16'd0, er});
    check("clip_l", {31'd0, clip_l}, {31'd0, ecl});
    check("clip_r", {31'd0, clip_r}, {31'd0, ecr});
    ol  = out_l;
    orr = out_r;
    finish_transfer(hold);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [15:0] ol, orr, el, er, keep;
    logic        ecl, ecr;
    int          n, seen;

    // Reset state
    repeat (3) @(posedge clk_sys);
    #1;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_muted", {31'd0, muted}, 32'd0);
    check("rst_out", {out_l, out_r}, 32'd0);
    check("rst_flags", {29'd0, overrun, clip_l, clip_r}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk_sys); #1;

    // Single unity channel to both sides
    do_sample(64'h0000_0000_0000_1000, 4'hF, 32'h0000_0080, 8'h03, 1, ol, orr);
    check("unity_l", {16'd0, ol}, 32'h1000);
    check("unity_r", {16'd0, orr}, 32'h1000);

    // All channels hot, left only: saturation
    do_sample(64'h7000_7000_7000_7000, 4'hF, 32'hFFFF_FFFF, 8'h55, 0, ol, orr);
    check("sat_l", {16'd0, ol}, 32'h7FFF);
    check("sat_r", {16'd0, orr}, 32'h0000);

    // Offset-binary zero is full negative scale
    do_sample(64'h0000_0000_0000_0000, 4'hE, 32'h0000_0080, 8'h03, 0, ol, orr);
    check("offbin_l", {16'd0, ol}, 32'h8000);
    check("offbin_r", {16'd0, orr}, 32'h8000);

    // Overrun during ACCUM and during a stalled OUTPUT; accept on transfer
    model(64'h0000_0000_0000_1000, 4'hF, 32'h0000_0080, 8'h03, mg, el, er, ecl, ecr);
    start_sample(64'h0000_0000_0000_1000, 4'hF, 32'h0000_0080, 8'h03);
    @(posedge clk_sys); #1;
    sample_stb = 1'b1;
    @(posedge clk_sys); #1;
    sample_stb = 1'b0;
    @(negedge clk_sys);
    check("ovr_accum", {31'd0, overrun}, 32'd1);
    @(posedge clk_sys); #1;
    wait_valid(n);
    check("stall_first_l", {16'd0, out_l}, {16'd0, el});
    keep = out_l;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_sys); #1;
      if (i == 5) begin
        ch_data = 64'h1111_2222_3333_4444;
        sample_stb = 1'b1;
      end
      if (i == 6) sample_stb = 1'b0;
      @(negedge clk_sys);
      if (i == 6) check("ovr_output", {31'd0, overrun}, 32'd1);
      if (i == 7) check("ovr_pulse_end", {31'd0, overrun}, 32'd0);
    end
    check("stall_valid", {31'd0, out_valid}, 32'd1);
    check("stall_out_l", {16'd0, out_l}, {16'd0, keep});
    // Strobe on the transfer cycle
    @(posedge clk_sys); #1;
    ch_data = 64'h0000_0000_0000_2000; ch_signed = 4'hF;
    ch_gain = 32'h0000_0040; ch_route = 8'h02;
    sample_stb = 1'b1;
    out_ready  = 1'b1;
    @(posedge clk_sys); #1;
    sample_stb = 1'b0;
    out_ready  = 1'b0;
    @(negedge clk_sys);
    check("xfer_no_ovr", {31'd0, overrun}, 32'd0);
    check("xfer_valid_low", {31'd0, out_valid}, 32'd0);
    check("xfer_accepted", {31'd0, busy}, 32'd1);
    check("xfer_keep_l", {16'd0, out_l}, {16'd0, keep});
    model(64'h0000_0000_0000_2000, 4'hF, 32'h0000_0040, 8'h02, mg, el, er, ecl, ecr);
    @(posedge clk_sys); #1;
    wait_valid(n);
    check("b2b_latency", n, NUM_CH + 1);
    check("b2b_l", {16'd0, out_l}, {16'd0, el});
    check("b2b_r", {16'd0, out_r}, {16'd0, er});
    finish_transfer(0);

    // Fade out then fade in
    mute = 1'b1;
    for (int i = 0; i < 8; i++) begin
      do_sample(64'h0000_0000_0000_1000, 4'hF, 32'h0000_0080, 8'h03, 0, ol, orr);
      check("fade_out", {16'd0, ol}, 32'h1000 - 32'(i) * 32'h200);
    end
    check("muted_after_fade", {31'd0, muted}, 32'd1);
    mute = 1'b0;
    for (int i = 0; i < 9; i++) begin
      do_sample(64'h0000_0000_0000_1000, 4'hF, 32'h0000_0080, 8'h03, 0, ol, orr);
      check("fade_in", {16'd0, ol}, 32'(i) * 32'h200);
    end

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      mute = ($urandom_range(0, 3) == 0);
      do_sample({$urandom, $urandom}, 4'($urandom), $urandom, 8'($urandom),
                $urandom_range(0, 3), ol, orr);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk_sys); #1;
      end
    end

    // Reset mid-ACCUM with a reduced master gain
    mute = 1'b1;
    do_sample(64'h0000_0000_0000_1000, 4'hF, 32'h0000_0080, 8'h03, 0, ol, orr);
    do_sample(64'h0000_0000_0000_1000, 4'hF, 32'h0000_0080, 8'h03, 0, ol, orr);
    mute = 1'b0;
    start_sample(64'h0000_0000_0000_7000, 4'hF, 32'h0000_0080, 8'h03);
    @(posedge clk_sys); #1;
    @(posedge clk_sys); #1;
    reset_n = 1'b0;
    #1;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    mg = 128;
    repeat (2) @(posedge clk_sys);
    #1;
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_sys);
      if (out_valid) seen++;
      @(posedge clk_sys); #1;
    end
    check("rst_no_output", seen, 0);
    do_sample(64'h0000_0000_0000_1000, 4'hF, 32'h0000_0080, 8'h03, 0, ol, orr);
    check("rst_master_unity", {16'd0, ol}, 32'h1000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/audio_channel_mixer.md
AUDIO_CHANNEL_MIXER -- requirements
Module: audio_channel_mixer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of input channels (1..8).
REQ-002 SHALL have parameter DW, default 16, per-channel sample width (8..24).
REQ-003 SHALL have parameter OUT_W, default 16, output sample width (8..24).
REQ-004 SHALL have parameter RAMP_STEP, default 1, master-gain change per output transfer (1..128).
REQ-005 SHALL have port clk_sys  in  1  core system clock; all logic on its rising edge.
REQ-006 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port sample_stb  in  1  one-cycle pulse: new sample set on ch_data.
REQ-008 SHALL have port ch_data  in  NUM_CH*DW  packed samples, ch0 in LSBs.
REQ-009 SHALL have port ch_signed  in  NUM_CH  per-channel: 1 = two's complement, 0 = offset binary.
REQ-010 SHALL have port ch_gain  in  NUM_CH*8  per-channel unsigned gain, 128 = unity.
REQ-011 SHALL have port ch_route  in  NUM_CH*2  bit0 = feed left, bit1 = feed right.
REQ-012 SHALL have port mute  in  1  request fade-out; deassert = fade-in.
REQ-013 SHALL have ports out_valid out 1, out_ready in 1, out_l out OUT_W, out_r out OUT_W (signed).
REQ-014 SHALL have ports busy, overrun, clip_l, clip_r, muted, each out 1.

Function
REQ-015 SHALL implement FSM IDLE -> ACCUM -> SCALE -> OUTPUT -> IDLE.
REQ-016 IDLE: sample_stb SHALL latch ch_data, ch_signed, ch_gain, ch_route, clear both accumulators, go to ACCUM.
REQ-017 ACCUM SHALL last exactly NUM_CH cycles, processing channel k in cycle k (k = 0..NUM_CH-1).
REQ-018 Per channel: offset-binary samples SHALL have MSB inverted; signed sample times zero-extended gain SHALL be added to the left and/or right accumulator per route bits.
REQ-019 Accumulator width SHALL be DW+9+clog2(NUM_CH); no internal overflow possible.
REQ-020 SCALE (1 cycle): each sum SHALL be arithmetic-shifted right 7, multiplied by master gain (0..128), shifted right 7, saturated to signed DW range, then aligned to OUT_W (left shift by OUT_W-DW if larger, arithmetic right shift truncation if smaller).
REQ-021 clip_l/clip_r SHALL pulse one cycle at the SCALE->OUTPUT transition when that channel saturated.
REQ-022 out_valid SHALL assert NUM_CH+2 cycles after the accepted sample_stb and hold with out_l/out_r stable until out_ready=1.
REQ-023 Transfer = out_valid & out_ready; next cycle SHALL be IDLE with out_valid=0; out_l/out_r keep last value.
REQ-024 sample_stb in ACCUM, SCALE or OUTPUT without same-cycle transfer SHALL be dropped and pulse overrun for one cycle.
REQ-025 sample_stb coincident with a transfer in OUTPUT SHALL be accepted (go directly to ACCUM), no overrun.
REQ-026 Master gain SHALL update on each transfer: mute=1 -> decrement by RAMP_STEP, floor 0; mute=0 -> increment, ceiling 128; the transferred sample uses the pre-update value.
REQ-027 muted SHALL equal (master gain == 0); busy SHALL be 1 in every state except IDLE.

Reset
REQ-028 reset_n low SHALL asynchronously force IDLE, out_valid=0, out_l=out_r=0, overrun=clip_l=clip_r=0, busy=0, muted=0, master gain=128, accumulators=0.
REQ-029 Reset mid-operation SHALL discard the in-flight sample; no output transfer for it.

Structure
REQ-030 Package audio_mix_pkg SHALL hold the FSM state enum, UNITY_GAIN=128, GAIN_W=8, ROUTE_L/ROUTE_R bit indices.
REQ-031 Saturate-and-align logic SHALL be sub-module audio_mix_sat, instantiated once per output channel.

Verification (NUM_CH=4, DW=16, OUT_W=16)
REQ-032 ch0=0x1000 signed, gain 128, route 11, others gain 0 -> out_l=out_r=0x1000, out_valid 6 cycles after stb.
REQ-033 all ch=0x7000, gain 255, route 01 -> out_l=0x7FFF, clip_l pulse, out_r=0x0000, clip_r=0.
REQ-034 ch0=0x0000 offset binary, gain 128, route 11 -> out_l=out_r=0x8000, no clip.
REQ-035 out_ready=0 for 20 cycles, second stb during OUTPUT -> overrun pulse, out_l unchanged; out_ready=1 -> exactly one transfer; stb on transfer cycle -> accepted, no overrun.
REQ-036 RAMP_STEP=16, mute=1, input 0x1000 unity -> outputs 0x1000, 0x0E00, 0x0C00 ... 0x0000 after 8 transfers, muted=1; mute=0 -> ramps back to 0x1000.
REQ-037 reset_n low in ACCUM cycle 2 -> out_valid=0 and busy=0 immediately, master gain 128, no output for that sample.
